// File: rtl/precision_dispatch_scheduler_pkg.sv
// Shared types for the precision dispatch scheduler: precision classes,
// code-to-class mapping and scheduler states.
package tva_prec_pkg;

    typedef enum logic [1:0] {
        PREC_INT4 = 2'd0,
        PREC_INT8 = 2'd1,
        PREC_FP16 = 2'd2
    } prec_class_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_SCAN   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Every code above 1 (including 4'hF) falls into the fp16 class.
    function automatic prec_class_t code_to_class(input logic [3:0] code);
        if (code == 4'd0) begin
            return PREC_INT4;
        end else if (code == 4'd1) begin
            return PREC_INT8;
        end
        return PREC_FP16;
    endfunction

endpackage

// File: rtl/precision_dispatch_scheduler_counter.sv
// Combinational per-class population count over the flattened 4-bit code vector.
module prec_class_counter
    import tva_prec_pkg::*;
#(
    parameter int L  = 8,
    parameter int CW = $clog2(L + 1)
) (
    input  logic [4*L-1:0] codes,
    output logic [CW-1:0]  cnt_int4,
    output logic [CW-1:0]  cnt_int8,
    output logic [CW-1:0]  cnt_fp16
);

    always_comb begin
        cnt_int4 = '0;
        cnt_int8 = '0;
        cnt_fp16 = '0;
        for (int t = 0; t < L; t++) begin
            case (code_to_class(codes[4*t +: 4]))
                PREC_INT4: cnt_int4 = cnt_int4 + CW'(1);
                PREC_INT8: cnt_int8 = cnt_int8 + CW'(1);
                default:   cnt_fp16 = cnt_fp16 + CW'(1);
            endcase
        end
    end

endmodule

// File: rtl/precision_dispatch_scheduler.sv
// Runs the precision assigner once, latches its codes and class counts, then
// streams token indices grouped by class (int4, int8, fp16) over valid/ready.
module precision_dispatch_scheduler
    import tva_prec_pkg::*;
#(
    parameter int L  = 8,
    parameter int TW = $clog2(L),
    parameter int CW = $clog2(L + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           asg_start,
    input  logic           asg_done,
    input  logic [4*L-1:0] asg_prec,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [TW-1:0]  out_token,
    output logic [1:0]     out_prec,
    output logic           out_last,
    output logic [CW-1:0]  cnt_int4,
    output logic [CW-1:0]  cnt_int8,
    output logic [CW-1:0]  cnt_fp16
);

    // Handshake: a token transfers on a rising edge where out_valid and
    // out_ready are both high; out_valid is a function of registered state only,
    // and token/class are held while out_valid=1 and out_ready=0.

    state_t       state;
    state_t       state_next;
    logic [4*L-1:0] code_q;
    logic [CW-1:0]  cnt_int4_q, cnt_int8_q, cnt_fp16_q;
    logic [CW-1:0]  cnt_int4_in, cnt_int8_in, cnt_fp16_in;
    prec_class_t    cls;
    logic [TW-1:0]  ptr;
    logic [CW-1:0]  emitted;

    logic [3:0] cur_code;
    logic       scanning;
    logic       match;
    logic       step;
    logic       handshake;
    logic       last_tok;

    prec_class_counter #(.L(L), .CW(CW)) u_counter (
        .codes    (asg_prec),
        .cnt_int4 (cnt_int4_in),
        .cnt_int8 (cnt_int8_in),
        .cnt_fp16 (cnt_fp16_in)
    );

    assign cur_code  = code_q[{ptr, 2'b00} +: 4];
    assign scanning  = (state == S_SCAN);
    assign match     = scanning && (code_to_class(cur_code) == cls);
    assign step      = scanning && (!match || out_ready);
    assign handshake = match && out_ready;
    assign last_tok  = match && (emitted == CW'(L - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT:   if (asg_done) state_next = S_SCAN;
            S_SCAN:   if (handshake && last_tok) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q     <= '0;
            cnt_int4_q <= '0;
            cnt_int8_q <= '0;
            cnt_fp16_q <= '0;
            cls        <= PREC_INT4;
            ptr        <= '0;
            emitted    <= '0;
        end else if (state == S_WAIT && asg_done) begin
            code_q     <= asg_prec;
            cnt_int4_q <= cnt_int4_in;
            cnt_int8_q <= cnt_int8_in;
            cnt_fp16_q <= cnt_fp16_in;
            cls        <= PREC_INT4;
            ptr        <= '0;
            emitted    <= '0;
        end else if (scanning) begin
            if (step) begin
                if (ptr == TW'(L - 1)) begin
                    ptr <= '0;
                    // The final fp16 handshake always ends the run, so cls saturates.
                    if (cls != PREC_FP16) cls <= prec_class_t'(cls + 2'd1);
                end else begin
                    ptr <= ptr + TW'(1);
                end
            end
            if (handshake) emitted <= emitted + CW'(1);
        end
    end

    // Outputs are forced low while reset is asserted.
    always_comb begin
        busy      = !rst && (state != S_IDLE);
        done      = !rst && (state == S_DONE);
        asg_start = !rst && (state == S_LAUNCH);
        out_valid = !rst && match;
        out_last  = !rst && last_tok;
        out_token = (!rst && scanning) ? ptr : '0;
        out_prec  = (!rst && scanning) ? cls : 2'd0;
        cnt_int4  = rst ? '0 : cnt_int4_q;
        cnt_int8  = rst ? '0 : cnt_int8_q;
        cnt_fp16  = rst ? '0 : cnt_fp16_q;
    end

endmodule
